// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default sizing constants and
// the helper that derives pointer width (address bits plus one wrap bit).
package sync_fifo_pkg;

    localparam int SYNC_FIFO_DEPTH_DEF = 8;
    localparam int SYNC_FIFO_WIDTH_DEF = 32;

    // Pointer width is the address width plus one extra wrap bit, so that a
    // full buffer and an empty buffer produce different pointer pairs.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write port and a registered read
// port. The read register clears on reset; the array itself is never cleared.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = SYNC_FIFO_DEPTH_DEF,
    parameter int DATA_WIDTH = SYNC_FIFO_WIDTH_DEF,
    parameter int ADDR_WIDTH = ptr_width(FIFO_DEPTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Write port: the array has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: the output register only updates on an accepted read, so it
    // holds the last word delivered until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with chip-select-qualified write/read requests,
// registered read data and full/empty flags decoded from wrap-bit pointers.
// Optional feature: define SYNC_FIFO_ERR_EN to add overflow/underflow pulses.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = SYNC_FIFO_DEPTH_DEF,
    parameter int DATA_WIDTH = SYNC_FIFO_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_WIDTH  = ptr_width(FIFO_DEPTH);
    localparam int ADDR_WIDTH = PTR_WIDTH - 1;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 wr_accept;
    logic                 rd_accept;

    // Flags come only from the registered pointers, never from the requests.
    // Equal pointers mean empty; equal addresses with opposite wrap bits mean
    // the writer is exactly one lap ahead, i.e. full.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    end

    // Each request is judged on its own against the pre-edge flags, which
    // lets a simultaneous write and read both proceed when neither flag is set.
    always_comb begin
        wr_accept = cs && wr_en && !full;
        rd_accept = cs && rd_en && !empty;
    end

    // Write pointer advances on every accepted write; natural overflow gives
    // the modulo 2*FIFO_DEPTH wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer advances on every accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    sync_fifo_mem #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (data_out)
    );

`ifdef SYNC_FIFO_ERR_EN
    // Error pulses: one cycle high after an edge that saw a rejected write
    // (full) or a rejected read (empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= cs && wr_en && full;
            underflow <= cs && rd_en && empty;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             cs;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
`ifdef SYNC_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored words plus the expected output
    // register and error pulses.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_ovf;
    logic             exp_unf;

    sync_fifo #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare every visible output against the model.
    task automatic check_output(input string tag);
        logic exp_empty;
        logic exp_full;
        exp_empty = (model_q.size() == 0);
        exp_full  = (model_q.size() == DEPTH);
        checks++;
        assert (empty === exp_empty) else begin
            errors++;
            $error("FAIL %s empty: observed %b expected %b", tag, empty, exp_empty);
        end
        checks++;
        assert (full === exp_full) else begin
            errors++;
            $error("FAIL %s full: observed %b expected %b", tag, full, exp_full);
        end
        checks++;
        assert (data_out === exp_data) else begin
            errors++;
            $error("FAIL %s data_out: observed %0h expected %0h", tag, data_out, exp_data);
        end
`ifdef SYNC_FIFO_ERR_EN
        checks++;
        assert (overflow === exp_ovf) else begin
            errors++;
            $error("FAIL %s overflow: observed %b expected %b", tag, overflow, exp_ovf);
        end
        checks++;
        assert (underflow === exp_unf) else begin
            errors++;
            $error("FAIL %s underflow: observed %b expected %b", tag, underflow, exp_unf);
        end
`endif
    endtask

    // Drive one cycle of requests, advance the model by the FIFO rules using
    // the occupancy before the edge, then check just after the edge.
    task automatic apply_stimulus(input logic c, input logic w, input logic r,
                                  input logic [WIDTH-1:0] d, input string tag);
        bit was_full;
        bit was_empty;
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        exp_ovf   = c && w && was_full;
        exp_unf   = c && r && was_empty;
        if (c && r && !was_empty) exp_data = model_q.pop_front();
        if (c && w && !was_full)  model_q.push_back(d);
        #1;
        check_output(tag);
    endtask

    task automatic write_word(input logic [WIDTH-1:0] d, input string tag);
        apply_stimulus(1'b1, 1'b1, 1'b0, d, tag);
    endtask

    task automatic read_word(input string tag);
        apply_stimulus(1'b1, 1'b0, 1'b1, '0, tag);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int wr_pct;
        int rd_pct;
        rst_n    = 1'b0;
        cs       = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        exp_data = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset");
        rst_n = 1'b1;

        $display("[TB] basic order");
        write_word(32'd1, "basic_wr");
        write_word(32'd10, "basic_wr");
        write_word(32'd100, "basic_wr");
        for (int i = 0; i < 4; i++) read_word("basic_rd");

        $display("[TB] interleaved");
        for (int i = 0; i < 8; i++) begin
            write_word(32'd1 << i, "inter_wr");
            read_word("inter_rd");
        end

        $display("[TB] fill and overflow");
        for (int i = 0; i < 9; i++) write_word(32'd1 << i, "fill_wr");
        for (int i = 0; i < 8; i++) read_word("fill_rd");
        read_word("underflow_rd");

        $display("[TB] simultaneous");
        for (int i = 0; i < 4; i++) write_word(32'hA000 + i, "sim_pre");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1, $urandom, "sim_rw");
            checks++;
            assert (model_q.size() == 4) else begin
                errors++;
                $error("FAIL sim_occupancy: observed %0d expected 4", model_q.size());
            end
        end

        $display("[TB] chip select");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b1, $urandom, "cs_off");

        $display("[TB] simultaneous at full and empty");
        for (int i = 0; i < 4; i++) write_word($urandom, "top_up");
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, "full_rw");
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, "full_rw2");

        $display("[TB] asynchronous reset");
        rst_n = 1'b0;
        #1;
        model_q.delete();
        exp_data = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        check_output("async_reset");
        #2;
        rst_n = 1'b1;
        read_word("post_reset_rd");
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678, "empty_rw");
        read_word("empty_rw_rd");

        $display("[TB] random traffic");
        for (int phase = 0; phase < 4; phase++) begin
            wr_pct = (phase % 2 == 0) ? 75 : 25;
            rd_pct = 100 - wr_pct;
            for (int i = 0; i < 100; i++) begin
                apply_stimulus($urandom_range(0, 9) != 0,
                               $urandom_range(0, 99) < wr_pct,
                               $urandom_range(0, 99) < rd_pct,
                               $urandom, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised first-in/first-out buffer with a chip-select-qualified write/read interface and registered read data. It decouples a producer and a consumer running in the same clock domain and reports `full`/`empty` status so that neither side overruns or underruns the buffer. It is a leaf datapath block with no dependencies beyond the shared package.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: number of entries. Must be a power of two, 2 or greater.
- `DATA_WIDTH`, default 32: word width in bits.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `cs`, input, 1: chip select; qualifies both `wr_en` and `rd_en`.
- `wr_en`, input, 1: write request.
- `rd_en`, input, 1: read request.
- `data_in`, input, DATA_WIDTH: write data.
- `data_out`, output, DATA_WIDTH: registered read data.
- `empty`, output, 1: FIFO holds no entries.
- `full`, output, 1: FIFO holds `FIFO_DEPTH` entries.

## Operation
- Storage is a `FIFO_DEPTH` × `DATA_WIDTH` array.
- The write and read pointers are each `$clog2(FIFO_DEPTH)+1` bits wide. The low bits index the array; the MSB is a wrap bit.
- `empty` is asserted when the two pointers are equal.
- `full` is asserted when the low bits are equal and the MSBs differ.
- Both flags are decoded combinationally from the registered pointers.
- **Accepted write:** `cs & wr_en & !full`. The array entry at `wr_ptr` is loaded with `data_in`, and `wr_ptr` increments.
- **Accepted read:** `cs & rd_en & !empty`. `data_out` is loaded with the entry at `rd_ptr`, and `rd_ptr` increments.
- **Write while full:** silently dropped. Pointers and contents are unchanged.
- **Read while empty:** silently ignored. `data_out` holds its last value.
- **Simultaneous write and read:** each is evaluated independently against the pre-edge flags.
  - Not empty and not full: both occur; occupancy is unchanged.
  - Full: only the read occurs.
  - Empty: only the write occurs.
- **`cs` = 0:** all requests are ignored and state holds.
- **Wrap-around:** pointers increment modulo `2*FIFO_DEPTH` with natural overflow; no special handling is needed.
- **Reset:**
  - `wr_ptr`, `rd_ptr` = 0; `data_out` = 0; hence `empty` = 1 and `full` = 0.
  - Array contents are not reset.
  - Reset mid-operation discards all stored data immediately (asynchronously).

## Timing
- Write latency: data written at edge N is readable by a read accepted at edge N+1. `empty` deasserts after edge N.
- Read latency: with `rd_en` sampled high at edge N, `data_out` is valid after edge N and stable until the next accepted read.
- Flags change only after a clock edge (or on reset assertion). They never depend combinationally on `wr_en`, `rd_en` or `cs`.
- Throughput: one write and one read per cycle.

## Configuration
- `SYNC_FIFO_ERR_EN` defined adds two outputs, each 1 bit:
  - `overflow`: pulses high for one cycle after an edge where `cs & wr_en & full`.
  - `underflow`: pulses high for one cycle after an edge where `cs & rd_en & empty`.
  - Both reset to 0.
- Without the macro, neither port nor its logic exists. All other behaviour is identical.

## Structure
- Package `sync_fifo_pkg`:
  - Default-value constants `SYNC_FIFO_DEPTH_DEF` = 8 and `SYNC_FIFO_WIDTH_DEF` = 32.
  - Function `ptr_width(depth)` returning `$clog2(depth)+1`.
- Sub-module `sync_fifo_mem`: the storage array.
  - Synchronous write port, registered read port.
  - Pointer and flag logic stays in `sync_fifo`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → `empty`=1, `full`=0, `data_out`=0 immediately; a following read returns nothing new.
- **Basic order:** write 1, 10, 100, then four reads → `data_out` = 1, 10, 100, then 100 held; `empty`=1 after the third read.
- **Interleaved:** for i=0..7, write 2^i, then read → each read returns 2^i; `empty`=1 after every read; `full` never asserts.
- **Fill and overflow:** write 2^0..2^8 (9 writes) → `full`=1 after the 8th write; 256 is dropped (`overflow` pulses if enabled). Eight reads then return 1, 2, …, 128, with `empty`=1 at the end.
- **Simultaneous:** with 4 entries, hold `cs`, `wr_en` and `rd_en` for 16 cycles → occupancy stays 4, data order is preserved across pointer wrap, and no flag toggles.
- **Chip select:** `cs`=0 with `wr_en`=`rd_en`=1 → no pointer, flag or `data_out` change.
